xpmwrap_sdpram_rd_burst: RTL

- Read-side burst engine that sits directly downstream of the simple dual-port RAM wrapper, in common-clock mode, and drives its port B.
- Accepts a burst command (start address, beat count) and issues one RAM read per cycle.
- Tracks the fixed 2-cycle RAM read latency and delivers the words on a valid/ready stream with a last flag.
- Credit-based output FIFO guarantees no data is lost under backpressure.

---
 rtl/xpmwrap_sdpram_rd_burst.sv | 130 +++++++++++++
 1 files changed

// File: rtl/xpmwrap_sdpram_rd_burst.sv
// xpmwrap_sdpram_rd_burst: port-B burst reader with read-latency tracking and a credit-gated FWFT output FIFO.
// Define XPMWRAP_RD_BURST_ADDR_TAG_EN to add m_addr, the RAM address each beat was read from.
module xpmwrap_sdpram_rd_burst #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 8,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    output logic                  ram_rstb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef XPMWRAP_RD_BURST_ADDR_TAG_EN
    output logic [ADDR_WIDTH-1:0] m_addr,
`endif
    output logic                  busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

    logic [0:0]              state;
    logic                    armed;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    rem_q;
    logic [READ_LATENCY-1:0] pv, pl;
    logic [DATA_WIDTH-1:0]   f_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   f_last;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count, inflight;
    logic                    empty, issue, push, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(pv[i]);
    end

    // Reads in flight plus buffered words never exceed the FIFO depth, so pushes cannot overflow.
    assign issue      = state == ISSUE && (inflight + count) < CW'(FIFO_DEPTH);
    assign empty      = count == '0;
    assign push       = pv[READ_LATENCY-1];
    assign pop        = !empty && m_ready;
    assign cmd_ready  = armed && state == IDLE && inflight == '0 && empty;
    assign busy       = state == ISSUE || inflight != '0 || !empty;
    assign ram_enb    = issue;
    assign ram_addrb  = addr_q;
    assign ram_rstb   = 1'b0;
    assign m_valid    = !empty;
    assign m_data     = f_data[rd_ptr];
    assign m_last     = !empty && f_last[rd_ptr];

    generate
        if (READ_LATENCY == 1) begin : g_rce_direct
            assign ram_regceb = issue;
        end else begin : g_rce_pipe
            assign ram_regceb = pv[READ_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            armed  <= 1'b0;
            addr_q <= '0;
            rem_q  <= '0;
            pv     <= '0;
            pl     <= '0;
        end else begin
            armed <= 1'b1;
            pv    <= (pv << 1) | READ_LATENCY'(issue);
            pl    <= (pl << 1) | READ_LATENCY'(issue && rem_q == '0);
            if (state == IDLE) begin
                if (cmd_valid && cmd_ready) begin
                    addr_q <= cmd_addr;
                    rem_q  <= cmd_len;
                    state  <= ISSUE;
                end
            end else if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                rem_q  <= rem_q - LEN_WIDTH'(1);
                if (rem_q == '0) state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_data[wr_ptr] <= ram_doutb;
            f_last[wr_ptr] <= pl[READ_LATENCY-1];
        end
    end

`ifdef XPMWRAP_RD_BURST_ADDR_TAG_EN
    logic [ADDR_WIDTH-1:0] pa     [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] f_addr [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        pa[0] <= addr_q;
        for (int i = 1; i < READ_LATENCY; i++) pa[i] <= pa[i-1];
        if (push) f_addr[wr_ptr] <= pa[READ_LATENCY-1];
    end

    assign m_addr = empty ? '0 : f_addr[rd_ptr];
`endif
endmodule
